// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit controller:
//   - tx_state_e         : controller FSM states
//   - DEFAULT_DATA_BITS  : default number of data bits per frame
//   - DEFAULT_OVERSAMPLE : default number of tick16 pulses per bit period
//   - STOP_BITS_ONE/TWO  : stop-bit counts selectable per frame
//   - SUB_TICK_W         : width of the per-bit sub-tick counter
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    localparam int STOP_BITS_ONE = 1;
    localparam int STOP_BITS_TWO = 2;

    localparam int SUB_TICK_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Serialises one data word per request into a UART frame:
// start bit, DATA_BITS data bits (LSB first), optional parity bit,
// and one or two stop bits. Bit timing comes from an external
// divide-by-16 baud counter through tick16; this block restarts that
// counter's phase with div_clear whenever a new frame is accepted.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high reset
//   tick16     in   one-cycle pulse from the baud divider
//   tx_valid   in   requester has a word to send
//   tx_data    in   word to send, sampled on accept
//   parity_en  in   append parity bit, sampled on accept
//   parity_odd in   1 = odd parity, 0 = even, sampled on accept
//   two_stop   in   1 = two stop bits, sampled on accept
//   tx_ready   out  controller can accept a word (IDLE only)
//   tx_out     out  registered serial line, idle high
//   busy       out  frame in progress
//   div_clear  out  one-cycle pulse restarting the divider phase
//   done       out  one-cycle pulse in the first IDLE cycle after STOP
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick16,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 div_clear,
    output logic                 done
);

    // The bit counter must be able to hold DATA_BITS itself, since it
    // increments on the final data bit as well.
    localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);

    localparam logic [BIT_CNT_W-1:0]  BIT_LAST      = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE       = BIT_CNT_W'(1);
    localparam logic [SUB_TICK_W-1:0] TICK_LAST     = SUB_TICK_W'(OVERSAMPLE - 1);
    localparam logic [SUB_TICK_W-1:0] TICK_ONE      = SUB_TICK_W'(1);
    localparam logic [1:0]            STOP_LAST_ONE = 2'(STOP_BITS_ONE - 1);
    localparam logic [1:0]            STOP_LAST_TWO = 2'(STOP_BITS_TWO - 1);

    tx_state_e              r_state;
    tx_state_e              w_nextState;

    logic [SUB_TICK_W-1:0]  r_subTick;
    logic [BIT_CNT_W-1:0]   r_bitCnt;
    logic [1:0]             r_stopCnt;
    logic [DATA_BITS-1:0]   r_shift;

    logic                   r_parityEn;
    logic                   r_twoStop;
    logic                   r_parityBit;

    logic                   r_txOut;
    logic                   r_done;

    logic                   w_nextTxOut;
    logic                   w_frameDone;
    logic                   w_accept;
    logic                   w_bitEnd;
    logic                   w_lastData;
    logic                   w_lastStop;
    logic                   w_parityNow;
    logic [DATA_BITS-1:0]   w_shiftNext;

    // Accept is gated by reset so that div_clear stays low while reset is held.
    assign w_accept    = tx_valid && (r_state == IDLE) && !reset;

    // A bit period ends on the tick16 seen while the sub-tick counter is at
    // its last value; ticks in IDLE (including one coincident with accept)
    // never count.
    assign w_bitEnd    = tick16 && (r_state != IDLE) && (r_subTick == TICK_LAST);

    assign w_shiftNext = r_shift >> 1;
    assign w_lastData  = (r_bitCnt == BIT_LAST);
    assign w_lastStop  = (r_stopCnt == (r_twoStop ? STOP_LAST_TWO : STOP_LAST_ONE));

    // Parity of the word being accepted, folded with the odd/even select so
    // only a single bit has to be held for the whole frame.
    assign w_parityNow = (^tx_data) ^ parity_odd;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. tx_out is computed here as the value the line takes
    // on entry to the next bit, so the registered line only changes at state
    // or bit boundaries.
    always_comb begin
        w_nextState = r_state;
        w_nextTxOut = r_txOut;
        w_frameDone = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_nextTxOut = 1'b1;
                if (w_accept) begin
                    w_nextState = START;
                    w_nextTxOut = 1'b0;
                end
            end

            START: begin
                if (w_bitEnd) begin
                    w_nextState = DATA;
                    w_nextTxOut = r_shift[0];
                end
            end

            DATA: begin
                if (w_bitEnd) begin
                    if (w_lastData) begin
                        if (r_parityEn) begin
                            w_nextState = PARITY;
                            w_nextTxOut = r_parityBit;
                        end else begin
                            w_nextState = STOP;
                            w_nextTxOut = 1'b1;
                        end
                    end else begin
                        w_nextTxOut = w_shiftNext[0];
                    end
                end
            end

            PARITY: begin
                if (w_bitEnd) begin
                    w_nextState = STOP;
                    w_nextTxOut = 1'b1;
                end
            end

            STOP: begin
                w_nextTxOut = 1'b1;
                if (w_bitEnd && w_lastStop) begin
                    w_nextState = IDLE;
                    w_frameDone = 1'b1;
                end
            end

            default: begin
                w_nextState = IDLE;
                w_nextTxOut = 1'b1;
            end
        endcase
    end

    // Datapath: frame configuration latch, sub-tick/bit/stop counters,
    // shift register, and the registered line and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_subTick   <= '0;
            r_bitCnt    <= '0;
            r_stopCnt   <= '0;
            r_shift     <= '0;
            r_parityEn  <= 1'b0;
            r_twoStop   <= 1'b0;
            r_parityBit <= 1'b0;
            r_txOut     <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_txOut <= w_nextTxOut;
            r_done  <= w_frameDone;

            if (w_accept) begin
                r_shift     <= tx_data;
                r_parityEn  <= parity_en;
                r_twoStop   <= two_stop;
                r_parityBit <= w_parityNow;
                r_subTick   <= '0;
                r_bitCnt    <= '0;
                r_stopCnt   <= '0;
            end else if ((r_state != IDLE) && tick16) begin
                if (w_bitEnd) begin
                    r_subTick <= '0;
                    if (r_state == DATA) begin
                        r_shift  <= w_shiftNext;
                        r_bitCnt <= r_bitCnt + BIT_ONE;
                    end
                    if (r_state == STOP) begin
                        r_stopCnt <= r_stopCnt + 2'd1;
                    end
                end else begin
                    r_subTick <= r_subTick + TICK_ONE;
                end
            end
        end
    end

    assign tx_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign tx_out    = r_txOut;
    assign done      = r_done;
    assign div_clear = w_accept;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed bench for uart_tx_ctrl. Each accepted word pushes the expected
// serial bit sequence into a queue; the frame watcher pops one bit at a time
// and requires the line (plus busy/ready/done/div_clear) to hold that value
// for a full bit period of 16 tick16 pulses.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 tick16;
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 parity_en;
    logic                 parity_odd;
    logic                 two_stop;
    logic                 tx_ready;
    logic                 tx_out;
    logic                 busy;
    logic                 div_clear;
    logic                 done;

    int checks     = 0;
    int errors     = 0;
    int cycleNum   = 0;
    int tickBase   = 0;
    int tickPeriod = 1;

    logic expBits[$];

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick16     (tick16),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .tx_ready   (tx_ready),
        .tx_out     (tx_out),
        .busy       (busy),
        .div_clear  (div_clear),
        .done       (done)
    );

    // Parity by counting ones; odd parity makes the total count odd.
    function automatic logic parityOf(input logic [7:0] d, input logic odd);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) ones++;
        end
        if (odd) return (ones % 2 == 0);
        return (ones % 2 == 1);
    endfunction

    // Move to just after the next rising edge and drive tick16 for the new cycle.
    task automatic advance();
        @(posedge clk);
        #1;
        cycleNum++;
        tick16 = (((cycleNum - tickBase) % tickPeriod) == 0);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present a word and queue its expected frame bits.
    task automatic applyStimulus(input logic [7:0] d, input logic pEn, input logic pOdd, input logic ts);
        tx_valid   = 1'b1;
        tx_data    = d;
        parity_en  = pEn;
        parity_odd = pOdd;
        two_stop   = ts;
        expBits.push_back(1'b0);
        for (int i = 0; i < DATA_BITS; i++) expBits.push_back(d[i]);
        if (pEn) expBits.push_back(parityOf(d, pOdd));
        expBits.push_back(1'b1);
        if (ts) expBits.push_back(1'b1);
    endtask

    task automatic acceptCycle(input string tag, input logic [7:0] d, input logic pEn,
                               input logic pOdd, input logic ts, input logic expDone);
        advance();
        applyStimulus(d, pEn, pOdd, ts);
        #3;
        checkOutput({tag, "_accept"}, {4'b0, tx_ready, div_clear, done, tx_out},
                    {4'b0, 1'b1, 1'b1, expDone, 1'b1});
    endtask

    // Pop each expected bit and require it to be held for one bit period.
    task automatic watchFrame(input string tag, input logic holdValid, input logic scramble,
                              input logic [7:0] heldData);
        int   bitLen;
        int   bitIdx;
        logic expBit;
        logic [4:0] obs;
        logic [4:0] exp;
        logic [4:0] bad;
        bitLen = OVERSAMPLE * tickPeriod;
        bitIdx = 0;
        while (expBits.size() > 0) begin
            expBit = expBits.pop_front();
            exp    = {1'b1, 1'b0, 1'b0, 1'b0, expBit};
            bad    = exp;
            for (int c = 0; c < bitLen; c++) begin
                advance();
                if (holdValid) begin
                    tx_valid = 1'b1;
                    tx_data  = heldData;
                end else begin
                    tx_valid = 1'b0;
                end
                if (scramble) begin
                    tx_data    = 8'($urandom);
                    parity_en  = 1'($urandom);
                    parity_odd = 1'($urandom);
                    two_stop   = 1'($urandom);
                end
                #3;
                obs = {busy, tx_ready, done, div_clear, tx_out};
                if ((obs !== exp) && (bad === exp)) bad = obs;
            end
            checkOutput($sformatf("%s_bit%0d", tag, bitIdx), {3'b0, bad}, {3'b0, exp});
            bitIdx++;
        end
    endtask

    task automatic doneCycle(input string tag);
        advance();
        tx_valid = 1'b0;
        #3;
        checkOutput({tag, "_done"}, {4'b0, done, tx_ready, busy, tx_out}, 8'b0000_1101);
        advance();
        #3;
        checkOutput({tag, "_done_clr"}, {7'b0, done}, 8'h00);
    endtask

    initial begin
        logic [2:0] idleObs;
        logic [2:0] idleBad;

        // Reset held for two edges with a request pending: reset must win.
        reset      = 1'b1;
        tick16     = 1'b1;
        tx_valid   = 1'b1;
        tx_data    = 8'hFF;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        advance();
        advance();
        reset    = 1'b0;
        tx_valid = 1'b0;
        #3;
        checkOutput("rst_tx_out",    {7'b0, tx_out},    8'h01);
        checkOutput("rst_tx_ready",  {7'b0, tx_ready},  8'h01);
        checkOutput("rst_busy",      {7'b0, busy},      8'h00);
        checkOutput("rst_done",      {7'b0, done},      8'h00);
        checkOutput("rst_div_clear", {7'b0, div_clear}, 8'h00);

        // Idle ticks must not start anything.
        for (int i = 0; i < 3; i++) advance();
        #3;
        checkOutput("idle_ticks", {6'b0, busy, tx_out}, 8'h01);

        // 0xA5, no parity, one stop bit.
        $display("[TB] frame 0xA5 8N1");
        acceptCycle("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        watchFrame("a5", 1'b0, 1'b0, 8'h00);
        doneCycle("a5");

        // 0x07 with even then odd parity.
        $display("[TB] frame 0x07 even/odd parity");
        acceptCycle("p_even", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        watchFrame("p_even", 1'b0, 1'b0, 8'h00);
        doneCycle("p_even");
        acceptCycle("p_odd", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        watchFrame("p_odd", 1'b0, 1'b0, 8'h00);
        doneCycle("p_odd");

        // Two stop bits, tx_valid held with the next word waiting; the
        // second accept lands on the done cycle.
        $display("[TB] back-to-back with two stop bits");
        acceptCycle("b2b1", 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
        watchFrame("b2b1", 1'b1, 1'b0, 8'h3C);
        acceptCycle("b2b2", 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
        watchFrame("b2b2", 1'b0, 1'b0, 8'h00);
        doneCycle("b2b2");

        // Slow ticks with the request on a tick cycle; inputs scrambled mid-frame.
        $display("[TB] tick every 4 cycles, config scrambled mid-frame");
        tickPeriod = 4;
        tickBase   = cycleNum + 1;
        acceptCycle("slow", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        watchFrame("slow", 1'b0, 1'b1, 8'h00);
        doneCycle("slow");

        // Reset during data bit 3 aborts the frame without a done pulse.
        $display("[TB] reset mid-frame");
        tickPeriod = 1;
        tickBase   = 0;
        acceptCycle("abort", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 69; i++) begin
            advance();
            tx_valid = 1'b0;
        end
        #3;
        checkOutput("abort_midbit3", {6'b0, busy, tx_out}, 8'h02);
        advance();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        #3;
        checkOutput("abort_state", {3'b0, tx_out, tx_ready, busy, done, div_clear}, 8'b0001_1000);
        expBits.delete();
        idleBad = 3'b010;
        for (int i = 0; i < 200; i++) begin
            advance();
            #3;
            idleObs = {done, tx_out, busy};
            if ((idleObs !== 3'b010) && (idleBad === 3'b010)) idleBad = idleObs;
        end
        checkOutput("abort_no_done", {5'b0, idleBad}, 8'b0000_0010);

        acceptCycle("clean", 8'h81, 1'b1, 1'b1, 1'b1, 1'b0);
        watchFrame("clean", 1'b0, 1'b0, 8'h00);
        doneCycle("clean");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
